memory_game_ctrl: RTL and testbench
===================================

Name: memory_game_ctrl

Overview:
Top-level round sequencer for the memory game. It generates a pseudo-random symbol sequence, plays the first `level` symbols on the LEDs, then accepts player button presses and compares each one to the stored sequence. On a correct round it advances the level; on a wrong press or a timeout the game ends. It drives the game-in-progress qualifier, and `start` re-arms it from IDLE, WIN or LOSE.

Parameters:
- MAX_LEN, 16: maximum sequence length; reaching it wins the game. Range 2..32.
- SHOW_TICKS, 25000000: clk cycles each symbol's LED is lit.
- GAP_TICKS, 12500000: clk cycles LEDs are dark between symbols and before each playback.
- TIMEOUT_TICKS, 250000000: clk cycles allowed between presses in INPUT.
- SEED, 16'hACE1: LFSR reset value. Must be non-zero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  level-sampled start request, debounced upstream.
- btn_valid  in  1  one-cycle pulse: player pressed a button.
- btn_code  in  2  button index, valid with btn_valid.
- led_en  out  1  playback LED enable.
- led_code  out  2  symbol being shown; 0 when led_en=0.
- in_game  out  1  high from GEN through INPUT (game-in-progress qualifier).
- accept  out  1  high only in INPUT; player presses are taken.
- level  out  $clog2(MAX_LEN+1)  current round length; 0 in IDLE.
- win  out  1  held high in WIN.
- lose  out  1  held high in LOSE.

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0; level=0.
  - LFSR=SEED; idx=0; timer=0.
  - The sequence RAM is not cleared.
- LFSR:
  - 16-bit Galois, taps 16'hB400.
  - Free-running: it steps every cycle after reset, so game seeds depend on when `start` is pressed.
- IDLE, WIN, LOSE:
  - start=1 -> GEN, with idx=0, level=0, win=lose=0.
  - start is ignored in every other state.
- GEN:
  - Writes mem[idx]=lfsr[1:0], one entry per cycle, for MAX_LEN cycles.
  - Then sets level=1, idx=0, timer=0 and goes to GAP.
- GAP:
  - led_en=0; counts GAP_TICKS cycles, then goes to SHOW.
- SHOW:
  - led_en=1, led_code=mem[idx], held for SHOW_TICKS cycles.
  - If idx==level-1: idx=0, timer=0 -> INPUT.
  - Otherwise: idx++ -> GAP.
- INPUT (accept=1, led_en=0). On btn_valid:
  - Mismatch (btn_code!=mem[idx]) -> LOSE.
  - Match with idx<level-1: idx++, timer=0.
  - Match with idx==level-1 and level==MAX_LEN -> WIN.
  - Match with idx==level-1 and level<MAX_LEN: level++, idx=0, timer=0 -> GAP.
- INPUT timeout:
  - If no btn_valid arrives and timer reaches TIMEOUT_TICKS-1 -> LOSE.
  - If btn_valid arrives in that same cycle, the press wins over the timeout.
- btn_valid outside INPUT is ignored and has no side effects.
- Timers:
  - Every state entry clears timer.
  - Each terminal count means exactly N cycles spent in that state.
- WIN/LOSE:
  - level holds its final value.
  - win or lose is held until start or reset.
- Reset mid-game returns to IDLE within one cycle, with the reset values above.
- All outputs are registered. led_code and led_en change on the cycle of the state transition.

Decomposition:
- Shared package memory_game_pkg:
  - state enum: IDLE, GEN, GAP, SHOW, INPUT, WIN, LOSE.
  - LFSR_TAPS constant.
  - symbol type: 2-bit.
- Sub-module lfsr16: clk, reset, SEED parameter, 16-bit q output.
- The sequence RAM is inferred inside the controller (MAX_LEN x 2 bits).

Test Plan (parameters MAX_LEN=4, SHOW_TICKS=3, GAP_TICKS=2, TIMEOUT_TICKS=10):
1. Reset, then start=1 for one cycle:
   - GEN lasts 4 cycles.
   - led_en is 0 for 2 cycles, then 1 for 3 cycles with led_code equal to the bench model's mem[0].
   - Then accept=1 and level=1.
2. Replay the correct code for each round:
   - level steps 1, 2, 3, 4.
   - Round k shows k symbols.
   - After the 4th correct press, win=1, in_game=0, level=4.
3. Round 2, first press correct, second press equals (mem[1]+1)%4:
   - lose=1 on the next cycle.
   - level stays 2.
   - Further btn_valid pulses change nothing.
4. In INPUT, no press:
   - lose asserts exactly 10 cycles after INPUT entry.
   - Separately: a correct btn_valid in the terminal cycle -> no lose; timer restarts.
5. btn_valid pulses during GAP/SHOW, and start=1 during INPUT:
   - Both are ignored.
   - Playback and level are unchanged.
6. Assert reset during SHOW:
   - Next cycle: all outputs 0, state IDLE.
   - A subsequent start begins a fresh GEN.

Source files
------------

// File: rtl/memory_game_pkg.sv
// Shared types and constants for the memory game round sequencer.
package memory_game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GEN,
    GAP,
    SHOW,
    INPUT,
    WIN,
    LOSE
  } state_e;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef logic [1:0] symbol_t;

  // One step of the right-shifting Galois LFSR.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/memory_game_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR; steps every cycle out of reset.
module lfsr16
  import memory_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  logic [15:0] q_q;

  always_ff @(posedge clk) begin
    if (reset) q_q <= SEED;
    else       q_q <= lfsr_step(q_q);
  end

  assign q = q_q;

endmodule

// File: rtl/memory_game_ctrl.sv
// Round sequencer: generates a symbol sequence, plays back `level` symbols,
// then checks the player's presses against it.
module memory_game_ctrl
  import memory_game_pkg::*;
#(
  parameter int unsigned MAX_LEN       = 16,
  parameter int unsigned SHOW_TICKS    = 25000000,
  parameter int unsigned GAP_TICKS     = 12500000,
  parameter int unsigned TIMEOUT_TICKS = 250000000,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               btn_valid,
  input  logic [1:0]                         btn_code,
  output logic                               led_en,
  output logic [1:0]                         led_code,
  output logic                               in_game,
  output logic                               accept,
  output logic [$clog2(MAX_LEN+1)-1:0]       level,
  output logic                               win,
  output logic                               lose
);

  localparam int unsigned LVL_W   = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W   = $clog2(MAX_LEN);
  localparam int unsigned TMR_MX0 = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int unsigned TMR_MAX = (TIMEOUT_TICKS > TMR_MX0) ? TIMEOUT_TICKS : TMR_MX0;
  localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic                 led_en_q, in_game_q, accept_q, win_q, lose_q;
  symbol_t              led_code_q;
  logic                 mem_we;
  logic                 last_idx;
  logic [15:0]          lfsr_q;
  logic                 lfsr_unused;
  symbol_t              mem [MAX_LEN];

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign lfsr_unused = ^lfsr_q[15:2];
  assign last_idx    = (LVL_W'(idx_q) == level_q - LVL_W'(1));

  // Sequence RAM; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx_q] <= lfsr_q[1:0];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    level_d = level_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d = GEN;
          idx_d   = '0;
          level_d = '0;
          timer_d = '0;
        end
      end
      GEN: begin
        mem_we = 1'b1;
        if (idx_q == IDX_W'(MAX_LEN - 1)) begin
          state_d = GAP;
          idx_d   = '0;
          level_d = LVL_W'(1);
          timer_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      GAP: begin
        if (timer_q == TMR_W'(GAP_TICKS - 1)) begin
          state_d = SHOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SHOW: begin
        if (timer_q == TMR_W'(SHOW_TICKS - 1)) begin
          timer_d = '0;
          if (last_idx) begin
            state_d = INPUT;
            idx_d   = '0;
          end else begin
            state_d = GAP;
            idx_d   = idx_q + IDX_W'(1);
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      INPUT: begin
        // A press in the terminal timeout cycle takes priority over the timeout.
        if (btn_valid) begin
          timer_d = '0;
          if (btn_code != mem[idx_q]) begin
            state_d = LOSE;
          end else if (!last_idx) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (level_q == LVL_W'(MAX_LEN)) begin
            state_d = WIN;
          end else begin
            state_d = GAP;
            level_d = level_q + LVL_W'(1);
            idx_d   = '0;
          end
        end else if (timer_q == TMR_W'(TIMEOUT_TICKS - 1)) begin
          state_d = LOSE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change with the transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      timer_q    <= '0;
      level_q    <= '0;
      led_en_q   <= 1'b0;
      led_code_q <= '0;
      in_game_q  <= 1'b0;
      accept_q   <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      level_q    <= level_d;
      led_en_q   <= (state_d == SHOW);
      led_code_q <= (state_d == SHOW) ? mem[idx_d] : '0;
      in_game_q  <= state_d inside {GEN, GAP, SHOW, INPUT};
      accept_q   <= (state_d == INPUT);
      win_q      <= (state_d == WIN);
      lose_q     <= (state_d == LOSE);
    end
  end

  assign led_en   = led_en_q;
  assign led_code = led_code_q;
  assign in_game  = in_game_q;
  assign accept   = accept_q;
  assign level    = level_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed/randomized bench for memory_game_ctrl with a behavioural game model.
module tb_memory_game_ctrl;

  localparam int unsigned MAX_LEN = 4;
  localparam int unsigned SHOW_T  = 3;
  localparam int unsigned GAP_T   = 2;
  localparam int unsigned TO_T    = 10;
  localparam logic [15:0] SEED    = 16'hACE1;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       btn_valid;
  logic [1:0] btn_code;
  logic       led_en;
  logic [1:0] led_code;
  logic       in_game;
  logic       accept;
  logic [2:0] level;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_lfsr;
  int unsigned m_mem [MAX_LEN];

  memory_game_ctrl #(
    .MAX_LEN       (MAX_LEN),
    .SHOW_TICKS    (SHOW_T),
    .GAP_TICKS     (GAP_T),
    .TIMEOUT_TICKS (TO_T),
    .SEED          (SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .btn_valid (btn_valid),
    .btn_code  (btn_code),
    .led_en    (led_en),
    .led_code  (led_code),
    .in_game   (in_game),
    .accept    (accept),
    .level     (level),
    .win       (win),
    .lose      (lose)
  );

  always #5 clk = ~clk;

  // Reference pseudo-random source: the value the design sees in any given cycle.
  always @(posedge clk) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_led_en"},   32'(led_en),   0);
    chk({tag, "_led_code"}, 32'(led_code), 0);
    chk({tag, "_in_game"},  32'(in_game),  0);
    chk({tag, "_accept"},   32'(accept),   0);
    chk({tag, "_level"},    32'(level),    0);
    chk({tag, "_win"},      32'(win),      0);
    chk({tag, "_lose"},     32'(lose),     0);
  endtask

  // Pulse start, then record the symbol captured in each generation cycle.
  task automatic start_game();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < int'(MAX_LEN); k++) begin
      chk("gen_in_game", 32'(in_game), 1);
      chk("gen_level",   32'(level),   0);
      chk("gen_led_en",  32'(led_en),  0);
      chk("gen_win_lose", 32'({win, lose}), 0);
      m_mem[k] = 32'(m_lfsr[1:0]);
      tick();
    end
  endtask

  // Expected playback of round `lv`: gap then symbol, lv times, ending in input.
  task automatic play_round(input int lv, input bit noise);
    for (int i = 0; i < lv; i++) begin
      for (int c = 0; c < int'(GAP_T); c++) begin
        chk("gap_led_en",  32'(led_en),  0);
        chk("gap_level",   32'(level),   32'(lv));
        chk("gap_in_game", 32'(in_game), 1);
        chk("gap_accept",  32'(accept),  0);
        if (noise) begin
          btn_valid = 1'($urandom);
          btn_code  = 2'($urandom);
        end
        tick();
        btn_valid = 1'b0;
      end
      for (int c = 0; c < int'(SHOW_T); c++) begin
        chk("show_led_en",   32'(led_en),   1);
        chk("show_led_code", 32'(led_code), m_mem[i]);
        chk("show_level",    32'(level),    32'(lv));
        if (noise) begin
          btn_valid = 1'($urandom);
          btn_code  = 2'($urandom);
        end
        tick();
        btn_valid = 1'b0;
      end
    end
    chk("input_accept", 32'(accept), 1);
    chk("input_led_en", 32'(led_en), 0);
    chk("input_level",  32'(level),  32'(lv));
  endtask

  task automatic press(input logic [1:0] code);
    btn_valid = 1'b1;
    btn_code  = code;
    tick();
    btn_valid = 1'b0;
  endtask

  task automatic wait_input(input int n, input bit noise_start);
    for (int c = 0; c < n; c++) begin
      chk("wait_accept", 32'(accept), 1);
      chk("wait_lose",   32'(lose),   0);
      start = noise_start ? 1'($urandom) : 1'b0;
      tick();
      start = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    btn_valid = 1'b0;
    btn_code  = 2'd0;
    tick();
    tick();
    reset = 1'b0;
    chk_outputs_zero("reset");

    // Idle for a random time with stray presses; nothing should move.
    for (int c = 0; c < int'($urandom_range(1, 8)); c++) begin
      btn_valid = 1'($urandom);
      btn_code  = 2'($urandom);
      tick();
      btn_valid = 1'b0;
      chk("idle_in_game", 32'(in_game), 0);
      chk("idle_level",   32'(level),   0);
    end

    // Game A: play every round correctly to a win, with ignored noise.
    start_game();
    for (int lv = 1; lv <= int'(MAX_LEN); lv++) begin
      play_round(lv, 1'b1);
      for (int i = 0; i < lv; i++) begin
        wait_input(int'($urandom_range(0, 5)), 1'b1);
        press(2'(m_mem[i]));
        if (i < lv - 1) begin
          chk("mid_accept", 32'(accept), 1);
          chk("mid_level",  32'(level),  32'(lv));
        end
      end
    end
    chk("win_win",     32'(win),     1);
    chk("win_lose",    32'(lose),    0);
    chk("win_in_game", 32'(in_game), 0);
    chk("win_accept",  32'(accept),  0);
    chk("win_level",   32'(level),   32'(MAX_LEN));
    press(2'($urandom));
    chk("win_hold",    32'({win, level}), 32'({1'b1, 3'(MAX_LEN)}));

    // Game B: wrong second press in round 2.
    start_game();
    play_round(1, 1'b0);
    press(2'(m_mem[0]));
    play_round(2, 1'b0);
    press(2'(m_mem[0]));
    chk("b_mid_accept", 32'(accept), 1);
    press(2'((m_mem[1] + 1) % 4));
    chk("b_lose",    32'(lose),    1);
    chk("b_win",     32'(win),     0);
    chk("b_level",   32'(level),   2);
    chk("b_in_game", 32'(in_game), 0);
    chk("b_accept",  32'(accept),  0);
    for (int c = 0; c < 3; c++) begin
      press(2'($urandom));
      chk("b_hold_lose",  32'(lose),   1);
      chk("b_hold_level", 32'(level),  2);
      chk("b_hold_led",   32'(led_en), 0);
    end

    // Game C: no press in round 1 times out exactly TO_T cycles after input entry.
    start_game();
    play_round(1, 1'b0);
    chk("c_entry_lose", 32'(lose), 0);
    for (int c = 1; c < int'(TO_T); c++) begin
      tick();
      chk("c_wait_lose",   32'(lose),   0);
      chk("c_wait_accept", 32'(accept), 1);
    end
    tick();
    chk("c_timeout_lose",   32'(lose),   1);
    chk("c_timeout_accept", 32'(accept), 0);
    chk("c_timeout_level",  32'(level),  1);

    // Game D: correct press in the terminal timeout cycle restarts the timer.
    start_game();
    play_round(1, 1'b0);
    press(2'(m_mem[0]));
    play_round(2, 1'b0);
    for (int c = 1; c < int'(TO_T); c++) tick();
    press(2'(m_mem[0]));
    chk("d_edge_lose",   32'(lose),   0);
    chk("d_edge_accept", 32'(accept), 1);
    for (int c = 1; c < int'(TO_T); c++) begin
      tick();
      chk("d_restart_lose", 32'(lose), 0);
    end
    tick();
    chk("d_timeout_lose",  32'(lose),  1);
    chk("d_timeout_level", 32'(level), 2);

    // Game E: reset in the middle of a SHOW, then a fresh game.
    start_game();
    for (int c = 0; c < int'(GAP_T); c++) tick();
    chk("e_show_led_en", 32'(led_en), 1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_outputs_zero("e_reset");
    for (int c = 0; c < int'($urandom_range(0, 3)); c++) tick();
    chk("e_idle_in_game", 32'(in_game), 0);
    start_game();
    play_round(1, 1'b0);
    press(2'(m_mem[0]));
    chk("e_next_level",  32'(level),  2);
    chk("e_next_accept", 32'(accept), 0);
    chk("e_next_led",    32'(led_en), 0);
    play_round(2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
